multiport_dpram_sclk: RTL

Single-clocked RAM with one byte-enabled write port and NUM_RD independent read ports. Read latency is configurable to 1 or 2 cycles, and each read port has a per-port valid strobe. Optional byte-granular same-cycle write-to-read bypass is provided. It is the generalised successor of our simple dual-port RAM, and is used for register files and multi-reader lookup tables in the accelerator datapath.

---
 rtl/multiport_dpram_sclk.sv | 110 +++++++++++
 1 files changed

// File: rtl/multiport_dpram_sclk.sv
// Single-clock RAM with one byte-enabled write port and NUM_RD independent read
// ports, 1- or 2-cycle registered read latency and optional same-edge bypass.
module multiport_dpram_sclk #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int NUM_MEM       = 32,
    parameter int NUM_RD        = 2,
    parameter int READ_LATENCY  = 1,
    parameter int ENABLE_BYPASS = 1,
    localparam int NUM_BE       = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         wr_en,
    input  logic [NUM_BE-1:0]            wr_be,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    input  logic [NUM_RD-1:0]            rd_en,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            rd_valid
);

    logic [DATA_WIDTH-1:0] mem [NUM_MEM];
    logic                  w_in_range;

    assign w_in_range = 32'(waddr) < 32'(NUM_MEM);

    // Memory contents are deliberately not reset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && w_in_range) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (wr_be[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Each port: rd_en[p] at edge T is a request that is always accepted (there is
    // no back-pressure); rd_valid[p] pulses exactly once, READ_LATENCY cycles later.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] ra;
        logic                  ra_ok;
        logic                  hit;
        logic [DATA_WIDTH-1:0] word;
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] out_data;
        logic                  out_valid;

        assign ra    = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign ra_ok = 32'(ra) < 32'(NUM_MEM);

        if (ENABLE_BYPASS != 0) begin : g_byp
            assign hit = wr_en && w_in_range && (waddr == ra);
        end else begin : g_nobyp
            assign hit = 1'b0;
        end

        // Out-of-range reads return zero; a same-edge hit merges enabled bytes of din.
        always_comb begin
            word = '0;
            if (ra_ok) begin
                word = mem[ra];
                if (hit) begin
                    for (int i = 0; i < NUM_BE; i++) begin
                        if (wr_be[i]) begin
                            word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_data  <= '0;
                s1_valid <= 1'b0;
            end else begin
                s1_valid <= rd_en[p];
                if (rd_en[p]) begin
                    s1_data <= word;
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_data <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            assign out_data  = s1_data;
            assign out_valid = s1_valid;
        end

        assign dout[p*DATA_WIDTH +: DATA_WIDTH] = out_data;
        assign rd_valid[p]                      = out_valid;
    end

endmodule
